// File: rtl/cpu_pkg.sv
// Shared CPU types for the register write-back path: widths, load-size
// encodings, the FIFO entry payload and the load extension helper.
package cpu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // i_mem_size encodings; 2'b11 is treated as a word access
  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // Select the addressed byte/half lane of a raw word and sign/zero extend it
  function automatic logic [DATA_W-1:0] load_extend(
    input logic [DATA_W-1:0] raw,
    input logic [1:0]        size,
    input logic              sext,
    input logic [1:0]        offset
  );
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DATA_W-1:0] res;
    lane_b = raw[{offset, 3'b000} +: 8];
    lane_h = raw[{offset[1], 4'b0000} +: 16];
    case (size)
      LD_BYTE: res = sext ? {{(DATA_W-8){lane_b[7]}}, lane_b}
                          : {{(DATA_W-8){1'b0}}, lane_b};
      LD_HALF: res = sext ? {{(DATA_W-16){lane_h[15]}}, lane_h}
                          : {{(DATA_W-16){1'b0}}, lane_h};
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back FIFO: two ordered push slots (slot 1 is only used
// together with slot 0), one pop port. Full/empty come from count alone.
// With WB_FWD_EN defined the raw storage and head pointer are exported
// for the forwarding lookup.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  push0,
  input  wb_entry_t             push0_entry,
  input  logic                  push1,
  input  wb_entry_t             push1_entry,
  input  logic                  pop,
  output wb_entry_t             head,
`ifdef WB_FWD_EN
  output wb_entry_t [DEPTH-1:0] entries,
  output logic [PTR_W-1:0]      head_ptr,
`endif
  output logic [CNT_W-1:0]      count
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      wr_ptr_p1;
  logic [1:0]            n_push;

  assign n_push    = {1'b0, push0} + {1'b0, push1};
  assign wr_ptr_p1 = wr_ptr + PTR_W'(1);
  assign head      = mem[rd_ptr];

`ifdef WB_FWD_EN
  assign entries  = mem;
  assign head_ptr = rd_ptr;
`endif

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      count  <= count + CNT_W'(n_push) - CNT_W'(pop);
    end
  end

  // Entry storage; slot 0 is older and lands first
  always_ff @(posedge i_clock) begin
    if (push0) begin
      mem[wr_ptr] <= push0_entry;
    end
    if (push1) begin
      mem[wr_ptr_p1] <= push1_entry;
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-port driver. Collects ALU and load results in
// program order (load older when both arrive together), extends load data
// at enqueue and issues one register write per cycle from the FIFO head.
// Optional macro WB_FWD_EN adds a combinational youngest-match lookup.
module reg_writeback
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_alu_valid,
  output logic              o_alu_ready,
  input  logic [ADDR_W-1:0] i_alu_addr,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic              i_mem_valid,
  output logic              o_mem_ready,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic [1:0]        i_mem_size,
  input  logic              i_mem_signed,
  input  logic [1:0]        i_mem_offset,
  output logic              o_RegWrite,
  output logic [ADDR_W-1:0] o_regW_addr,
  output logic [DATA_W-1:0] o_regW_val,
  output logic              o_busy
`ifdef WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] i_fwd_addr,
  output logic              o_fwd_hit,
  output logic [DATA_W-1:0] o_fwd_val
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count;
  wb_entry_t        head;
  wb_entry_t        mem_entry;
  wb_entry_t        alu_entry;
  wb_entry_t        slot0;
  wb_entry_t        slot1;
  logic             mem_fire;
  logic             alu_fire;
  logic             push0;
  logic             push1;
  logic             pop;

  // Readiness depends on registered occupancy only; a same-cycle pop is not credited
  assign o_mem_ready = (count <= CNT_W'(DEPTH - 1));
  assign o_alu_ready = (count <= CNT_W'(DEPTH - 2));
  assign mem_fire    = i_mem_valid & o_mem_ready;
  assign alu_fire    = i_alu_valid & o_alu_ready;
  assign pop         = (count != '0);

  // Build entries and pack accepted results into ordered push slots
  always_comb begin
    mem_entry      = '0;
    alu_entry      = '0;
    mem_entry.addr = i_mem_addr;
    mem_entry.data = load_extend(i_mem_data, i_mem_size, i_mem_signed, i_mem_offset);
    alu_entry.addr = i_alu_addr;
    alu_entry.data = i_alu_data;
    push0          = mem_fire | alu_fire;
    push1          = mem_fire & alu_fire;
    slot0          = mem_fire ? mem_entry : alu_entry;
    slot1          = alu_entry;
  end

`ifdef WB_FWD_EN
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  wb_entry_t [DEPTH-1:0] fifo_entries;
  logic [PTR_W-1:0]      fifo_head_ptr;
`endif

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .push0       (push0),
    .push0_entry (slot0),
    .push1       (push1),
    .push1_entry (slot1),
    .pop         (pop),
    .head        (head),
`ifdef WB_FWD_EN
    .entries     (fifo_entries),
    .head_ptr    (fifo_head_ptr),
`endif
    .count       (count)
  );

  // Output register: load the head on every pop; r0 writes are swallowed
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_RegWrite  <= 1'b0;
      o_regW_addr <= '0;
      o_regW_val  <= '0;
    end else if (pop) begin
      o_RegWrite  <= (head.addr != '0);
      o_regW_addr <= head.addr;
      o_regW_val  <= head.data;
    end else begin
      o_RegWrite  <= 1'b0;
    end
  end

  assign o_busy = (count != '0) || o_RegWrite;

`ifdef WB_FWD_EN
  // Youngest pending value wins: scan output register, then FIFO oldest to youngest
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    o_fwd_hit = 1'b0;
    o_fwd_val = '0;
    if (o_RegWrite && (o_regW_addr == i_fwd_addr)) begin
      o_fwd_hit = 1'b1;
      o_fwd_val = o_regW_val;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = fifo_head_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (fifo_entries[idx].addr == i_fwd_addr)) begin
        o_fwd_hit = 1'b1;
        o_fwd_val = fifo_entries[idx].data;
      end
    end
    if (i_fwd_addr == '0) begin
      o_fwd_hit = 1'b0;
      o_fwd_val = '0;
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: a queue-based reference model produces the
// expected register writes, a negedge monitor checks DUT outputs against it.
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic        i_clock;
  logic        i_reset;
  logic        i_alu_valid;
  logic        o_alu_ready;
  logic [4:0]  i_alu_addr;
  logic [31:0] i_alu_data;
  logic        i_mem_valid;
  logic        o_mem_ready;
  logic [4:0]  i_mem_addr;
  logic [31:0] i_mem_data;
  logic [1:0]  i_mem_size;
  logic        i_mem_signed;
  logic [1:0]  i_mem_offset;
  logic        o_RegWrite;
  logic [4:0]  o_regW_addr;
  logic [31:0] o_regW_val;
  logic        o_busy;
`ifdef WB_FWD_EN
  logic [4:0]  i_fwd_addr;
  logic        o_fwd_hit;
  logic [31:0] o_fwd_val;
`endif

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_alu_valid  (i_alu_valid),
    .o_alu_ready  (o_alu_ready),
    .i_alu_addr   (i_alu_addr),
    .i_alu_data   (i_alu_data),
    .i_mem_valid  (i_mem_valid),
    .o_mem_ready  (o_mem_ready),
    .i_mem_addr   (i_mem_addr),
    .i_mem_data   (i_mem_data),
    .i_mem_size   (i_mem_size),
    .i_mem_signed (i_mem_signed),
    .i_mem_offset (i_mem_offset),
    .o_RegWrite   (o_RegWrite),
    .o_regW_addr  (o_regW_addr),
    .o_regW_val   (o_regW_val),
`ifdef WB_FWD_EN
    .i_fwd_addr   (i_fwd_addr),
    .o_fwd_hit    (o_fwd_hit),
    .o_fwd_val    (o_fwd_val),
`endif
    .o_busy       (o_busy)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] val;
  } ent_t;

  ent_t pend_q[$];
  ent_t exp_q[$];
  int   total;
  int   bad;
  int   wr_seen;
  bit   mon_en;

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  // Load result from plain shift/mask arithmetic
  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] sz,
                                           input logic sg, input logic [1:0] off);
    logic [31:0] v;
    if (sz == 2'b00) begin
      v = (d >> (8 * off)) & 32'h0000_00FF;
      if (sg && v[7]) v = v - 32'h0000_0100;
    end else if (sz == 2'b01) begin
      v = (d >> (16 * (off / 2))) & 32'h0000_FFFF;
      if (sg && v[15]) v = v - 32'h0001_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending queue; head leaves every active edge, accepted results join behind
  always @(posedge i_clock) begin
    int   n;
    ent_t e;
    if (i_reset) begin
      pend_q.delete();
    end else begin
      n = pend_q.size();
      if (n > 0) begin
        e = pend_q.pop_front();
        if (e.addr != 5'd0) exp_q.push_back(e);
      end
      if (i_mem_valid && (DEPTH - n) >= 1)
        pend_q.push_back('{i_mem_addr, ref_load(i_mem_data, i_mem_size, i_mem_signed, i_mem_offset)});
      if (i_alu_valid && (DEPTH - n) >= 2)
        pend_q.push_back('{i_alu_addr, i_alu_data});
    end
  end

  // Monitor: readiness, busy, and every presented write against the scoreboard
  always @(negedge i_clock) begin
    int   n;
    ent_t e;
    if (mon_en) begin
      n = pend_q.size();
      chk("mem_ready", 32'(o_mem_ready), 32'(n <= DEPTH - 1));
      chk("alu_ready", 32'(o_alu_ready), 32'(n <= DEPTH - 2));
      chk("busy", 32'(o_busy), 32'((n != 0) || (exp_q.size() != 0)));
      chk("write_en", 32'(o_RegWrite), 32'(exp_q.size() != 0));
      if (o_RegWrite) wr_seen++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (o_RegWrite) begin
          chk("write_addr", 32'(o_regW_addr), 32'(e.addr));
          chk("write_val", o_regW_val, e.val);
        end
      end
    end
  end

  task automatic idle(input int n);
    i_mem_valid = 1'b0;
    i_alu_valid = 1'b0;
    repeat (n) @(negedge i_clock);
  endtask

  task automatic send(input bit mv, input logic [4:0] ma, input logic [31:0] md,
                      input logic [1:0] ms, input bit sg, input logic [1:0] mo,
                      input bit av, input logic [4:0] aa, input logic [31:0] ad);
    i_mem_valid  = mv;
    i_mem_addr   = ma;
    i_mem_data   = md;
    i_mem_size   = ms;
    i_mem_signed = sg;
    i_mem_offset = mo;
    i_alu_valid  = av;
    i_alu_addr   = aa;
    i_alu_data   = ad;
    @(negedge i_clock);
    i_mem_valid  = 1'b0;
    i_alu_valid  = 1'b0;
  endtask

  task automatic expect_write(input string name, input logic [4:0] a, input logic [31:0] v);
    chk({name, "_en"}, 32'(o_RegWrite), 32'd1);
    chk({name, "_addr"}, 32'(o_regW_addr), 32'(a));
    chk({name, "_val"}, o_regW_val, v);
  endtask

  initial begin
    int wr_before;
    total = 0;
    bad = 0;
    wr_seen = 0;
    mon_en = 1'b0;
    i_reset = 1'b1;
    i_alu_valid = 1'b0;
    i_alu_addr = '0;
    i_alu_data = '0;
    i_mem_valid = 1'b0;
    i_mem_addr = '0;
    i_mem_data = '0;
    i_mem_size = '0;
    i_mem_signed = 1'b0;
    i_mem_offset = '0;
`ifdef WB_FWD_EN
    i_fwd_addr = '0;
`endif
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    mon_en = 1'b1;

    // Reset state
    chk("rst_we", 32'(o_RegWrite), 32'd0);
    chk("rst_addr", 32'(o_regW_addr), 32'd0);
    chk("rst_val", o_regW_val, 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_alu_ready", 32'(o_alu_ready), 32'd1);

    // Single ALU result: write visible only two cycles after acceptance
    send(0, 5'd0, 32'd0, 2'b00, 0, 2'd0, 1, 5'd5, 32'h0000_1234);
    chk("lat_n1_we", 32'(o_RegWrite), 32'd0);
    @(negedge i_clock);
    expect_write("lat_n2", 5'd5, 32'h0000_1234);
    @(negedge i_clock);
    chk("lat_n3_we", 32'(o_RegWrite), 32'd0);
    chk("lat_hold_addr", 32'(o_regW_addr), 32'd5);
    idle(2);

    // Loads
    send(1, 5'd7, 32'h80FF_7F01, 2'b00, 1, 2'd3, 0, 5'd0, 32'd0);
    @(negedge i_clock);
    expect_write("ld_byte_s", 5'd7, 32'hFFFF_FF80);
    idle(2);
    send(1, 5'd8, 32'h80FF_7F01, 2'b01, 0, 2'd2, 0, 5'd0, 32'd0);
    @(negedge i_clock);
    expect_write("ld_half_u", 5'd8, 32'h0000_80FF);
    idle(2);

    // Same-cycle load and ALU to r3: load first
    send(1, 5'd3, 32'hAAAA_AAAA, 2'b10, 0, 2'd0, 1, 5'd3, 32'hBBBB_BBBB);
    @(negedge i_clock);
    expect_write("ord_first", 5'd3, 32'hAAAA_AAAA);
    @(negedge i_clock);
    expect_write("ord_second", 5'd3, 32'hBBBB_BBBB);
    @(negedge i_clock);
    chk("ord_final", o_regW_val, 32'hBBBB_BBBB);
    idle(2);

    // Fill to three entries, check back-pressure, then reset mid-stream
    send(1, 5'd1, 32'h1111_0001, 2'b10, 0, 2'd0, 1, 5'd2, 32'h2222_0002);
    send(1, 5'd4, 32'h4444_0004, 2'b10, 0, 2'd0, 1, 5'd6, 32'h6666_0006);
    chk("full3_alu_ready", 32'(o_alu_ready), 32'd0);
    chk("full3_mem_ready", 32'(o_mem_ready), 32'd1);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_we", 32'(o_RegWrite), 32'd0);
      @(negedge i_clock);
    end
    chk("post_rst_busy", 32'(o_busy), 32'd0);
    chk("post_rst_alu_ready", 32'(o_alu_ready), 32'd1);

    // r0 is consumed silently
    send(0, 5'd0, 32'd0, 2'b00, 0, 2'd0, 1, 5'd0, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      chk("r0_we", 32'(o_RegWrite), 32'd0);
      @(negedge i_clock);
    end

    // Continuous ALU stream: one write per cycle, nothing lost
    wr_before = wr_seen;
    for (int i = 0; i < 40; i++) begin
      send(0, 5'd0, 32'd0, 2'b00, 0, 2'd0, 1, 5'(1 + (i % 31)), $urandom);
      if (i >= 1) chk("stream_we", 32'(o_RegWrite), 32'd1);
    end
    idle(4);
    chk("stream_count", 32'(wr_seen - wr_before), 32'd40);

    // Randomized mix of loads and ALU results
    for (int i = 0; i < 300; i++) begin
      send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    end
    idle(8);
    chk("drain_exp_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_busy", 32'(o_busy), 32'd0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
